// File: rtl/uart_row_sender.sv
// -----------------------------------------------------------------------------
// uart_row_sender
//
// Host-side initiator for the row-upload protocol answered by
// uart2vga_with_answer. One accepted start sends a complete row:
//   - BYTE_SIZE_Y row-address bytes taken from row_y, low byte first,
//   - BYTE_SIZE_ROW pixel bytes read from an external byte memory,
//   - STOP_BYTE.
// Each byte goes to a uart_transmiter. The single answer byte coming back
// through a uart_receiver is checked before the next byte is sent. The
// transfer ends with one done pulse, and err_code holds the outcome.
//
// Ports
//   clk       system clock (the only clock domain)
//   rst_n     asynchronous active-low reset; aborts a transfer silently
//   start     1-cycle request to send one row, honoured only when idle
//   row_y     row number, captured when start is accepted
//   mem_rd    1-cycle read strobe to the pixel byte memory
//   mem_addr  pixel byte index 0..BYTE_SIZE_ROW-1
//   mem_data  memory read data, valid the cycle after mem_rd
//   tx_start  1-cycle strobe to the transmitter
//   tx_data   byte for the transmitter, held until answered or aborted
//   tx_busy   transmitter busy; tx_start is never raised while it is high
//   rx_data   byte from the receiver
//   rx_done   1-cycle receiver pulse per received byte
//   busy      high from accepted start until the transfer completes
//   done      1-cycle pulse when the transfer ends (success or failure)
//   err_code  0 ok, 1 wrong answer, 2 timeout, 3 not all received
//   missing   byte that followed NOT_ALL_RECEIVED, otherwise 0
// -----------------------------------------------------------------------------
module uart_row_sender #(
  parameter int         BYTE_SIZE_ROW         = 240,
  parameter int         BYTE_SIZE_Y           = 2,
  parameter logic [7:0] STOP_BYTE             = 8'hDD,
  parameter logic [7:0] ANSWER_CODE_TAKE_ROW  = 8'hCC,
  parameter logic [7:0] ANSWER_CODE           = 8'hAA,
  parameter logic [7:0] SUCCESSFULLY_RECEIVED = 8'hFF,
  parameter logic [7:0] NOT_ALL_RECEIVED      = 8'h11,
  parameter int         TIMEOUT_CYCLES        = 50000,
  parameter int         ADDR_W                = $clog2(BYTE_SIZE_ROW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       row_y,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [7:0]        missing
);

  localparam int N_BYTES = BYTE_SIZE_Y + BYTE_SIZE_ROW + 1;
  localparam int IDX_W   = $clog2(N_BYTES);
  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + 1);

  // Index of the first pixel byte and of the terminating STOP_BYTE.
  localparam logic [IDX_W-1:0] PIX_FIRST = IDX_W'(BYTE_SIZE_Y);
  localparam logic [IDX_W-1:0] STOP_IDX  = IDX_W'(N_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ANSWER  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_PARTIAL = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MEMWAIT,
    LOAD,
    SEND,
    WAIT_ANS,
    WAIT_MISS,
    FINISH
  } state_t;

  state_t           state;
  logic [15:0]      row_q;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic [IDX_W-1:0] pix_off;

  // Offset of the current byte within the pixel block; used only while idx
  // points at a pixel byte.
  assign pix_off = idx - PIX_FIRST;

  function automatic logic is_pixel(input logic [IDX_W-1:0] i);
    return (i >= PIX_FIRST) && (i < STOP_IDX);
  endfunction

  // Address bytes are sent low byte first: byte i is row[8*i +: 8].
  function automatic logic [7:0] addr_byte(input logic [15:0] row,
                                           input logic [IDX_W-1:0] i);
    logic [15:0] sh;
    sh = row >> {i, 3'b000};
    return sh[7:0];
  endfunction

  // Answer the responder must give for the byte at index i.
  function automatic logic [7:0] expected_answer(input logic [IDX_W-1:0] i);
    if (i < PIX_FIRST) begin
      return ANSWER_CODE_TAKE_ROW;
    end else if (i < STOP_IDX) begin
      return ANSWER_CODE;
    end else begin
      return SUCCESSFULLY_RECEIVED;
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_start <= 1'b0;
      mem_rd   <= 1'b0;
      tx_data  <= '0;
      mem_addr <= '0;
      err_code <= ERR_OK;
      missing  <= '0;
      row_q    <= '0;
      idx      <= '0;
      timer    <= '0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      done     <= 1'b0;
      tx_start <= 1'b0;
      mem_rd   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            row_q    <= row_y;
            idx      <= '0;
            err_code <= ERR_OK;
            missing  <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end

        // ---- byte fetch: only pixel bytes need a memory read ----
        FETCH: begin
          if (is_pixel(idx)) begin
            mem_rd   <= 1'b1;
            mem_addr <= pix_off[ADDR_W-1:0];
            state    <= MEMWAIT;
          end else begin
            state    <= LOAD;
          end
        end

        // mem_rd is visible this cycle; its data arrives in LOAD.
        MEMWAIT: begin
          state <= LOAD;
        end

        LOAD: begin
          if (idx < PIX_FIRST) begin
            tx_data <= addr_byte(row_q, idx);
          end else if (idx < STOP_IDX) begin
            tx_data <= mem_data;
          end else begin
            tx_data <= STOP_BYTE;
          end
          state <= SEND;
        end

        // ---- hand-off to the transmitter ----
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            timer    <= '0;
            state    <= WAIT_ANS;
          end
        end

        // ---- answer check; an answer in the timeout cycle still counts ----
        WAIT_ANS: begin
          if (rx_done) begin
            if (rx_data == expected_answer(idx)) begin
              if (idx == STOP_IDX) begin
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                idx   <= idx + 1'b1;
                state <= FETCH;
              end
            end else if ((idx == STOP_IDX) && (rx_data == NOT_ALL_RECEIVED)) begin
              err_code <= ERR_PARTIAL;
              timer    <= '0;
              state    <= WAIT_MISS;
            end else begin
              err_code <= ERR_ANSWER;
              done     <= 1'b1;
              state    <= FINISH;
            end
          end else if (timer == TMR_LAST) begin
            err_code <= ERR_TIMEOUT;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // The responder reports which byte it was missing; a timeout here
        // keeps the partial-reception code rather than reporting a timeout.
        WAIT_MISS: begin
          if (rx_done) begin
            missing <= rx_data;
            done    <= 1'b1;
            state   <= FINISH;
          end else if (timer == TMR_LAST) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // done is high during this cycle; start is not looked at here.
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_row_sender.md
Name: uart_row_sender

Overview:
- Host-side initiator for the row-upload protocol that uart2vga_with_answer answers.
- Sequence sent: 2 row-address bytes, BYTE_SIZE_ROW pixel bytes from an external byte memory, then STOP_BYTE.
- Each byte is handed to a uart_transmiter, and its one-byte answer from a uart_receiver is checked before the next byte.
- Used as an on-board loopback/self-test master and as a synthesizable bench driver.

Parameters:
BYTE_SIZE_ROW, 240, pixel bytes per row
BYTE_SIZE_Y, 2, row-address bytes (low byte first)
STOP_BYTE, 8'hDD, terminating byte
ANSWER_CODE_TAKE_ROW, 8'hCC, expected answer to each address byte
ANSWER_CODE, 8'hAA, expected answer to each pixel byte
SUCCESSFULLY_RECEIVED, 8'hFF, expected answer to STOP_BYTE
NOT_ALL_RECEIVED, 8'h11, partial-reception answer to STOP_BYTE
TIMEOUT_CYCLES, 50000, clk cycles allowed from tx_start to answer
ADDR_W, $clog2(BYTE_SIZE_ROW), width of mem_addr

Ports:
clk  in  1  system clock (one clock domain)
rst_n  in  1  asynchronous, active-low reset
start  in  1  1-cycle request to send one row; ignored unless idle
row_y  in  16  row number; latched on accepted start
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  pixel byte index 0..BYTE_SIZE_ROW-1
mem_data  in  8  read data, valid exactly 1 cycle after mem_rd
tx_start  out  1  1-cycle strobe to uart_transmiter start_strobe
tx_data  out  8  byte to uart_transmiter data; held stable until answer/abort
tx_busy  in  1  uart_transmiter busy
rx_data  in  8  uart_receiver data
rx_done  in  1  uart_receiver done, 1-cycle pulse per byte
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse at end of transfer (success or failure)
err_code  out  2  0 ok, 1 wrong answer, 2 timeout, 3 not all received; held until next accepted start
missing  out  8  byte following NOT_ALL_RECEIVED; else 0

Behaviour:
- Reset: state IDLE; busy, done, tx_start, mem_rd = 0; tx_data, mem_addr, err_code, missing, index, timer = 0.
- Reset mid-transfer aborts immediately, with no done pulse.
- Byte index idx runs 0..N-1, N = BYTE_SIZE_Y+BYTE_SIZE_ROW+1.
  - Byte for idx<BYTE_SIZE_Y is row_y[8*idx+:8].
  - Byte for idx<BYTE_SIZE_Y+BYTE_SIZE_ROW is mem[idx-BYTE_SIZE_Y].
  - Last byte is STOP_BYTE.
- States:
  - IDLE: start -> latch row_y, idx=0, err_code=0, missing=0, busy=1 -> FETCH.
  - FETCH: for pixel bytes, assert mem_rd 1 cycle with mem_addr -> MEMWAIT; other bytes -> LOAD directly.
  - MEMWAIT: 1 cycle -> LOAD.
  - LOAD: tx_data <= selected byte (mem_data for pixel bytes) -> SEND.
  - SEND: wait until tx_busy==0; then tx_start=1 for exactly 1 cycle, clear timer -> WAIT_ANS.
  - WAIT_ANS:
    - Timer increments each cycle; timer==TIMEOUT_CYCLES-1 without rx_done -> err_code=2 -> FINISH.
    - On rx_done, compare rx_data with the expected code for idx.
    - Match on non-last byte -> idx+1 -> FETCH.
    - Match (SUCCESSFULLY_RECEIVED) on last byte -> FINISH with err_code 0.
    - Last byte and NOT_ALL_RECEIVED -> err_code=3, clear timer -> WAIT_MISS.
    - Any other value -> err_code=1 -> FINISH.
  - WAIT_MISS: next rx_done -> missing=rx_data -> FINISH; timeout as above but err_code stays 3.
  - FINISH: done=1 one cycle, busy=0 -> IDLE.
- rx_done outside WAIT_ANS/WAIT_MISS is ignored, so stray bytes are dropped.
- rx_done in the same cycle as a timeout is accepted (answer wins).
- start while busy is ignored; start in the FINISH cycle is ignored.
- Minimum gap between tx_start pulses is one UART frame plus the responder turnaround; the block never issues tx_start while tx_busy=1.

Test Plan:
1. Nominal row (row_y=16'h2201, mem=incrementing 0x00.., responder model answers CC,CC,AA x240,FF):
   - bytes on tx_data are 01,22,00..EF,DD.
   - 243 tx_start pulses, one done, err_code=0, missing=0.
2. Responder answers 8'h55 to pixel byte 10:
   - Transfer stops after 13 tx_start pulses; done with err_code=1; no further tx_start.
3. Responder silent after byte 1:
   - done exactly TIMEOUT_CYCLES cycles after the 2nd tx_start; err_code=2.
4. Responder answers 11 then 8'h07 to STOP_BYTE:
   - done, err_code=3, missing=8'h07.
5. start pulsed repeatedly during a transfer:
   - Ignored; tx byte sequence identical to scenario 1; a new start after done is accepted, err_code clears to 0.
6. rst_n low for 3 cycles mid-pixel-stream:
   - All outputs at reset values within 0 cycles of assertion; no done pulse; the next start produces a clean full sequence.
